// File: rtl/commit_trace_buffer_pkg.sv
// Shared types and constants for the commit trace buffer: FSM states,
// record flag bit positions and the record-width helper.
package commit_trace_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    HALTED  = 2'd2,
    TIMEOUT = 2'd3
  } trace_state_e;

  localparam int FLG_RW  = 0;
  localparam int FLG_LD  = 1;
  localparam int FLG_ST  = 2;
  localparam int FLG_HLT = 3;
  localparam int FLAG_W  = 4;

  // Record layout: {cycle, flags, pc, waddr, wdata, maddr, mdata}
  function automatic int rec_width(input int data_w, input int reg_aw, input int cnt_w);
    return cnt_w + FLAG_W + 4 * data_w + reg_aw;
  endfunction

endpackage

// File: rtl/commit_trace_buffer_if.sv
// Bundle of the cpu event inputs, the trace record stream and the status
// outputs. The tracer uses the master view; the cpu/consumer side uses slave.
interface commit_trace_buffer_if
  import commit_trace_buffer_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int CNT_W  = 32
) ();
  localparam int REC_W = rec_width(DATA_W, REG_AW, CNT_W);

  logic              en;
  logic [DATA_W-1:0] pc;
  logic              reg_we;
  logic [REG_AW-1:0] reg_waddr;
  logic [DATA_W-1:0] reg_wdata;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              hlt;
  logic              trc_valid;
  logic              trc_ready;
  logic [REC_W-1:0]  trc_record;
  logic [CNT_W-1:0]  cycle_count;
  logic [CNT_W-1:0]  inst_count;
  logic [CNT_W-1:0]  drop_count;
  logic              overflow;
  logic              halted;
  logic              timeout;

  modport master (
    input  en, pc, reg_we, reg_waddr, reg_wdata, mem_rd, mem_wr,
           mem_addr, mem_wdata, mem_rdata, hlt, trc_ready,
    output trc_valid, trc_record, cycle_count, inst_count, drop_count,
           overflow, halted, timeout
  );

  modport slave (
    output en, pc, reg_we, reg_waddr, reg_wdata, mem_rd, mem_wr,
           mem_addr, mem_wdata, mem_rdata, hlt, trc_ready,
    input  trc_valid, trc_record, cycle_count, inst_count, drop_count,
           overflow, halted, timeout
  );
endinterface

// File: rtl/commit_trace_buffer_sync_fifo.sv
// Single-clock FIFO with a registered head word. A pushed word becomes
// visible on head one cycle later; push and pop may occur together, also
// when full. Pointers carry one extra MSB to tell full from empty.
module commit_trace_buffer_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = head_q;

  // Pointer advance and next head: an older stored entry if one remains
  // after the pop, otherwise the word arriving this cycle, otherwise hold.
  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    head_d   = head_q;
    if (wr_ptr_q != rd_ptr_d) begin
      head_d = mem_q[rd_ptr_d[AW-1:0]];
    end else if (do_push) begin
      head_d = push_data;
    end
  end

  // Storage array; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

  // Pointer and head registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      head_q   <= head_d;
    end
  end
endmodule

// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: samples per-cycle writeback/memory events while
// running, counts cycles and retired instructions, queues one record per
// event cycle and streams records out over valid/ready. Stops on halt or
// when the watchdog cycle limit is reached.
module commit_trace_buffer
  import commit_trace_buffer_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int REG_AW     = 4,
  parameter int DEPTH      = 16,
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 100000
) (
  input logic                 clk,
  input logic                 rst,
  commit_trace_buffer_if.master bus
);
  localparam int               REC_W      = rec_width(DATA_W, REG_AW, CNT_W);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] WDOG_LIMIT = CNT_W'(MAX_CYCLES);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  trace_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d, inst_q, inst_d, drop_q, drop_d;
  logic              overflow_q, overflow_d;
  logic              active, event_hit, retire;
  logic              fifo_full, fifo_empty, pop, push_ok, push;
  logic [FLAG_W-1:0] flags;
  logic [DATA_W-1:0] mdata;
  logic [REC_W-1:0]  rec;

  assign active    = (state_q == RUN) && bus.en;
  assign event_hit = bus.reg_we | bus.mem_rd | bus.mem_wr | bus.hlt;
  assign retire    = bus.reg_we | bus.mem_wr | bus.hlt;
  assign pop       = !fifo_empty && bus.trc_ready;
  // A full FIFO still accepts when its head leaves in the same cycle.
  assign push_ok   = !fifo_full || pop;
  assign push      = active && event_hit && push_ok;

  // Record packing; a store wins the data field when ld and st coincide.
  always_comb begin
    flags          = '0;
    flags[FLG_RW]  = bus.reg_we;
    flags[FLG_LD]  = bus.mem_rd;
    flags[FLG_ST]  = bus.mem_wr;
    flags[FLG_HLT] = bus.hlt;
    mdata          = '0;
    if (bus.mem_wr) begin
      mdata = bus.mem_wdata;
    end else if (bus.mem_rd) begin
      mdata = bus.mem_rdata;
    end
    rec = {cycle_q, flags, bus.pc, bus.reg_waddr, bus.reg_wdata, bus.mem_addr, mdata};
  end

  // Next state: halt beats the watchdog when both land on the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.en) state_d = RUN;
      RUN: begin
        if (!bus.en) begin
          state_d = IDLE;
        end else if (bus.hlt) begin
          state_d = HALTED;
        end else if (cycle_d == WDOG_LIMIT) begin
          state_d = TIMEOUT;
        end
      end
      default: state_d = state_q;
    endcase
  end

  // Saturating counters and sticky overflow, advanced only while capturing.
  always_comb begin
    cycle_d    = cycle_q;
    inst_d     = inst_q;
    drop_d     = drop_q;
    overflow_d = overflow_q;
    if (active) begin
      cycle_d = sat_inc(cycle_q);
      if (retire) begin
        inst_d = sat_inc(inst_q);
      end
      if (event_hit && !push_ok) begin
        drop_d     = sat_inc(drop_q);
        overflow_d = 1'b1;
      end
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cycle_q    <= '0;
      inst_q     <= '0;
      drop_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cycle_q    <= cycle_d;
      inst_q     <= inst_d;
      drop_q     <= drop_d;
      overflow_q <= overflow_d;
    end
  end

  commit_trace_buffer_sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (rec),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (bus.trc_record)
  );

  assign bus.trc_valid   = !fifo_empty;
  assign bus.cycle_count = cycle_q;
  assign bus.inst_count  = inst_q;
  assign bus.drop_count  = drop_q;
  assign bus.overflow    = overflow_q;
  assign bus.halted      = (state_q == HALTED);
  assign bus.timeout     = (state_q == TIMEOUT);
endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer with a 4-entry FIFO and a 20-cycle
// watchdog. Inputs change 1 time unit after a rising edge; outputs are
// checked at that same point, well away from the next edge.
module tb_commit_trace_buffer;
  localparam int REC_W = 104;  // 32 + 4 + 16 + 4 + 16 + 16 + 16

  logic clk;
  logic rst;
  int   tests;
  int   failures;

  commit_trace_buffer_if #(.DATA_W(16), .REG_AW(4), .CNT_W(32)) bus ();

  commit_trace_buffer #(
    .DATA_W(16), .REG_AW(4), .DEPTH(4), .CNT_W(32), .MAX_CYCLES(20)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [REC_W-1:0] make_rec(input logic [31:0] cyc, input logic [3:0] flg,
                                                input logic [15:0] pc_v, input logic [3:0] wa,
                                                input logic [15:0] wd, input logic [15:0] ma,
                                                input logic [15:0] md);
    return {cyc, flg, pc_v, wa, wd, ma, md};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    bus.pc = '0; bus.reg_we = 0; bus.reg_waddr = '0; bus.reg_wdata = '0;
    bus.mem_rd = 0; bus.mem_wr = 0; bus.mem_addr = '0; bus.mem_wdata = '0;
    bus.mem_rdata = '0; bus.hlt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.en = 0; bus.trc_ready = 0;
    clear_events();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (bus.trc_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %0b expected 0", bus.trc_valid); end
    tests++; if (bus.cycle_count !== 32'd0 || bus.inst_count !== 32'd0 || bus.drop_count !== 32'd0) begin
      failures++; $display("FAIL rst_counts: got %0d/%0d/%0d expected 0/0/0", bus.cycle_count, bus.inst_count, bus.drop_count); end
    tests++; if ({bus.overflow, bus.halted, bus.timeout} !== 3'b000) begin
      failures++; $display("FAIL rst_status: got %b expected 000", {bus.overflow, bus.halted, bus.timeout}); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_single_write();
    logic [REC_W-1:0] exp_rec;
    do_reset();
    bus.en = 1; bus.trc_ready = 1;
    step();                       // IDLE -> RUN
    step(); step();               // run cycles 0 and 1, no events
    bus.pc = 16'h0004; bus.reg_we = 1; bus.reg_waddr = 4'd3; bus.reg_wdata = 16'h00AB;
    step();                       // event at run cycle 2
    clear_events();
    exp_rec = make_rec(32'd2, 4'b0001, 16'h0004, 4'd3, 16'h00AB, 16'h0000, 16'h0000);
    tests++; if (bus.trc_valid !== 1'b1) begin failures++; $display("FAIL t1_valid: got %0b expected 1", bus.trc_valid); end
    tests++; if (bus.trc_record !== exp_rec) begin failures++; $display("FAIL t1_record: got %h expected %h", bus.trc_record, exp_rec); end
    tests++; if (bus.inst_count !== 32'd1) begin failures++; $display("FAIL t1_inst: got %0d expected 1", bus.inst_count); end
    tests++; if (bus.cycle_count !== 32'd3) begin failures++; $display("FAIL t1_cycle: got %0d expected 3", bus.cycle_count); end
    step();
    tests++; if (bus.trc_valid !== 1'b0) begin failures++; $display("FAIL t1_drained: got %0b expected 0", bus.trc_valid); end
    $display("[TB] test_single_write done");
  endtask

  task automatic test_load_and_write();
    logic [REC_W-1:0] exp_rec;
    do_reset();
    bus.en = 1; bus.trc_ready = 1;
    step();
    bus.pc = 16'h0008; bus.reg_we = 1; bus.reg_waddr = 4'd5; bus.reg_wdata = 16'h00CD;
    bus.mem_rd = 1; bus.mem_addr = 16'h0010; bus.mem_rdata = 16'h1234;
    step();                       // run cycle 0: load + writeback
    clear_events();
    bus.pc = 16'h000A; bus.mem_rd = 1; bus.mem_wr = 1; bus.mem_addr = 16'h0020;
    bus.mem_wdata = 16'h5555; bus.mem_rdata = 16'h9999;
    exp_rec = make_rec(32'd0, 4'b0011, 16'h0008, 4'd5, 16'h00CD, 16'h0010, 16'h1234);
    tests++; if (bus.trc_record !== exp_rec) begin failures++; $display("FAIL t2_ldrw_record: got %h expected %h", bus.trc_record, exp_rec); end
    tests++; if (bus.inst_count !== 32'd1) begin failures++; $display("FAIL t2_inst: got %0d expected 1", bus.inst_count); end
    step();                       // run cycle 1: ld+st, pops previous record
    clear_events();
    exp_rec = make_rec(32'd1, 4'b0110, 16'h000A, 4'd0, 16'h0000, 16'h0020, 16'h5555);
    tests++; if (bus.trc_record !== exp_rec) begin failures++; $display("FAIL t2_ldst_record: got %h expected %h", bus.trc_record, exp_rec); end
    tests++; if (bus.inst_count !== 32'd2) begin failures++; $display("FAIL t2_inst2: got %0d expected 2", bus.inst_count); end
    step();
    tests++; if (bus.trc_valid !== 1'b0) begin failures++; $display("FAIL t2_drained: got %0b expected 0", bus.trc_valid); end
    $display("[TB] test_load_and_write done");
  endtask

  task automatic test_overflow();
    logic [REC_W-1:0] exp_rec;
    do_reset();
    bus.en = 1; bus.trc_ready = 0;
    step();
    for (int i = 0; i < 6; i++) begin
      bus.pc = 16'(i); bus.reg_we = 1; bus.reg_waddr = 4'(i); bus.reg_wdata = 16'h0100 + 16'(i);
      step();
    end
    clear_events();
    tests++; if (bus.drop_count !== 32'd2) begin failures++; $display("FAIL t3_drop: got %0d expected 2", bus.drop_count); end
    tests++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL t3_overflow: got %0b expected 1", bus.overflow); end
    tests++; if (bus.inst_count !== 32'd6) begin failures++; $display("FAIL t3_inst: got %0d expected 6", bus.inst_count); end
    bus.trc_ready = 1;
    for (int i = 0; i < 4; i++) begin
      exp_rec = make_rec(32'(i), 4'b0001, 16'(i), 4'(i), 16'h0100 + 16'(i), 16'h0000, 16'h0000);
      tests++; if (bus.trc_valid !== 1'b1 || bus.trc_record !== exp_rec) begin
        failures++; $display("FAIL t3_drain%0d: got v=%0b %h expected v=1 %h", i, bus.trc_valid, bus.trc_record, exp_rec); end
      step();
    end
    tests++; if (bus.trc_valid !== 1'b0) begin failures++; $display("FAIL t3_empty: got %0b expected 0", bus.trc_valid); end
    $display("[TB] test_overflow done");
  endtask

  task automatic test_full_push_pop();
    logic [REC_W-1:0] exp_rec;
    do_reset();
    bus.en = 1; bus.trc_ready = 0;
    step();
    for (int i = 0; i < 4; i++) begin
      bus.reg_we = 1; bus.reg_waddr = 4'(i); bus.reg_wdata = 16'h0200 + 16'(i);
      step();
    end
    bus.reg_we = 1; bus.reg_waddr = 4'd9; bus.reg_wdata = 16'h0900; bus.trc_ready = 1;
    step();                       // full FIFO: pop and push in the same cycle
    clear_events();
    tests++; if (bus.drop_count !== 32'd0 || bus.overflow !== 1'b0) begin
      failures++; $display("FAIL t4_nodrop: got %0d/%0b expected 0/0", bus.drop_count, bus.overflow); end
    for (int i = 1; i < 5; i++) begin
      if (i < 4) exp_rec = make_rec(32'(i), 4'b0001, 16'h0000, 4'(i), 16'h0200 + 16'(i), 16'h0000, 16'h0000);
      else       exp_rec = make_rec(32'd4, 4'b0001, 16'h0000, 4'd9, 16'h0900, 16'h0000, 16'h0000);
      tests++; if (bus.trc_valid !== 1'b1 || bus.trc_record !== exp_rec) begin
        failures++; $display("FAIL t4_rec%0d: got v=%0b %h expected v=1 %h", i, bus.trc_valid, bus.trc_record, exp_rec); end
      step();
    end
    tests++; if (bus.trc_valid !== 1'b0) begin failures++; $display("FAIL t4_empty: got %0b expected 0", bus.trc_valid); end
    $display("[TB] test_full_push_pop done");
  endtask

  task automatic test_halt();
    logic [REC_W-1:0] exp_rec;
    do_reset();
    bus.en = 1; bus.trc_ready = 1;
    step();
    for (int i = 0; i < 9; i++) step();   // run cycles 0..8 idle
    bus.pc = 16'h0030; bus.hlt = 1; bus.reg_we = 1; bus.reg_waddr = 4'd2; bus.reg_wdata = 16'h0042;
    step();                               // halt at run cycle 9
    clear_events();
    exp_rec = make_rec(32'd9, 4'b1001, 16'h0030, 4'd2, 16'h0042, 16'h0000, 16'h0000);
    tests++; if (bus.halted !== 1'b1) begin failures++; $display("FAIL t5_halted: got %0b expected 1", bus.halted); end
    tests++; if (bus.trc_record !== exp_rec) begin failures++; $display("FAIL t5_record: got %h expected %h", bus.trc_record, exp_rec); end
    tests++; if (bus.cycle_count !== 32'd10) begin failures++; $display("FAIL t5_cycle: got %0d expected 10", bus.cycle_count); end
    for (int i = 0; i < 3; i++) begin
      bus.reg_we = 1; bus.reg_waddr = 4'd7; bus.mem_wr = 1;
      step();
    end
    clear_events();
    tests++; if (bus.cycle_count !== 32'd10 || bus.inst_count !== 32'd1) begin
      failures++; $display("FAIL t5_frozen: got %0d/%0d expected 10/1", bus.cycle_count, bus.inst_count); end
    tests++; if (bus.trc_valid !== 1'b0 || bus.halted !== 1'b1) begin
      failures++; $display("FAIL t5_ignored: got v=%0b h=%0b expected v=0 h=1", bus.trc_valid, bus.halted); end
    $display("[TB] test_halt done");
  endtask

  task automatic test_timeout_reset();
    do_reset();
    bus.en = 1; bus.trc_ready = 0;
    step();
    for (int i = 0; i < 19; i++) begin
      bus.reg_we = (i < 3); bus.reg_waddr = 4'(i);
      step();
    end
    clear_events();
    tests++; if (bus.timeout !== 1'b0 || bus.cycle_count !== 32'd19) begin
      failures++; $display("FAIL t6_pre: got to=%0b c=%0d expected to=0 c=19", bus.timeout, bus.cycle_count); end
    step();
    tests++; if (bus.timeout !== 1'b1 || bus.halted !== 1'b0 || bus.cycle_count !== 32'd20) begin
      failures++; $display("FAIL t6_timeout: got to=%0b h=%0b c=%0d expected to=1 h=0 c=20", bus.timeout, bus.halted, bus.cycle_count); end
    bus.trc_ready = 1;
    step();
    tests++; if (bus.cycle_count !== 32'd20 || bus.trc_valid !== 1'b1) begin
      failures++; $display("FAIL t6_drain: got c=%0d v=%0b expected c=20 v=1", bus.cycle_count, bus.trc_valid); end
    rst = 1'b1;
    step();
    tests++; if (bus.trc_valid !== 1'b0 || bus.cycle_count !== 32'd0 || bus.inst_count !== 32'd0 || bus.timeout !== 1'b0) begin
      failures++; $display("FAIL t6_rst: got v=%0b c=%0d i=%0d to=%0b expected 0/0/0/0",
                           bus.trc_valid, bus.cycle_count, bus.inst_count, bus.timeout); end
    rst = 1'b0;
    $display("[TB] test_timeout_reset done");
  endtask

  initial begin
    tests = 0; failures = 0; rst = 1'b1;
    bus.en = 0; bus.trc_ready = 0;
    clear_events();
    test_reset();
    test_single_write();
    test_load_and_write();
    test_overflow();
    test_full_push_pop();
    test_halt();
    test_timeout_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "time limit");
  end
endmodule
